// File: rtl/ifu.sv
// Instruction fetch unit: holds the architectural PC, fetches from imem
// over req/ack, presents Instr/PC/PC4 and commits the next PC on Advance.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-low reset (0 = reset)
//   nPCOp        next-PC select: 000 PC+4, 001 beq, 010 j/jal, 011 jr, 1xx PC+4
//   Zero         equality flag qualifying beq
//   Imm16        branch offset field
//   Index26      jump index field
//   RegA         jr target register value
//   Advance      current instruction complete, commit next PC
//   imem_req     fetch request
//   imem_addr    fetch address (equals PC)
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   instruction word from memory
//   Instr        latched instruction
//   InstrValid   Instr/PC/PC4 valid for decode/execute
//   PC           address of Instr
//   PC4          PC + 4 (link value)
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  nPCOp,
    input  logic        Zero,
    input  logic [15:0] Imm16,
    input  logic [25:0] Index26,
    input  logic [31:0] RegA,
    input  logic        Advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PC4
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_J   = 3'b010;
    localparam logic [2:0] OP_JR  = 3'b011;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    // PC+4 wraps naturally modulo 2^32.
    assign pc4 = pc_q + 32'd4;

    // Branch offset is the word offset sign-extended to a byte offset.
    assign br_off = {{14{Imm16[15]}}, Imm16, 2'b00};

    always_comb begin
        next_pc = pc4;
        case (nPCOp)
            OP_SEQ: next_pc = pc4;
            OP_BEQ: next_pc = Zero ? (pc4 + br_off) : pc4;
            OP_J:   next_pc = {pc4[31:28], Index26, 2'b00};
            // Misaligned jr targets are silently word-aligned.
            OP_JR:  next_pc = RegA & 32'hFFFF_FFFC;
            default: next_pc = pc4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (Advance) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Request is masked by reset so it drops as soon as reset is asserted.
    assign imem_req   = reset && (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = valid_q;
    assign PC         = pc_q;
    assign PC4        = pc4;

endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: directed test-plan steps followed by random
// instruction streams checked against a behavioural next-PC model.
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  nPCOp = 3'd0;
    logic        Zero = 1'b0;
    logic [15:0] Imm16 = 16'd0;
    logic [25:0] Index26 = 26'd0;
    logic [31:0] RegA = 32'd0;
    logic        Advance = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PC4;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_pc;
    logic [31:0] cur_instr;

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .nPCOp(nPCOp),
        .Zero(Zero),
        .Imm16(Imm16),
        .Index26(Index26),
        .RegA(RegA),
        .Advance(Advance),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .Instr(Instr),
        .InstrValid(InstrValid),
        .PC(PC),
        .PC4(PC4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference next-PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc,
                                            input logic [2:0] op,
                                            input logic z,
                                            input logic [15:0] imm,
                                            input logic [25:0] idx,
                                            input logic [31:0] rega);
        logic [31:0] p4;
        int off;
        p4 = pc + 32'd4;
        off = $signed(imm);
        off = off * 4;
        case (op)
            3'd1: return z ? p4 + 32'(off) : p4;
            3'd2: return (p4 & 32'hF000_0000) | (32'(idx) * 32'd4);
            3'd3: return (rega / 32'd4) * 32'd4;
            default: return p4;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        imem_ack = 1'b0;
        Advance = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_pc", PC, RST_PC);
        chk("rst_instr", Instr, 32'd0);
        reset = 1'b1;
        exp_pc = RST_PC;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] w, input int d);
        chk("f_req", 32'(imem_req), 32'd1);
        chk("f_addr", imem_addr, exp_pc);
        chk("f_valid0", 32'(InstrValid), 32'd0);
        for (int i = 0; i < d; i++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            Advance = 1'($urandom_range(0, 1));
            nPCOp = 3'($urandom_range(0, 7));
            RegA = $urandom;
            @(negedge clk);
            chk("fw_req", 32'(imem_req), 32'd1);
            chk("fw_addr", imem_addr, exp_pc);
            chk("fw_valid", 32'(InstrValid), 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = w;
        Advance = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_ack = 1'b0;
        Advance = 1'b0;
        chk("e_valid", 32'(InstrValid), 32'd1);
        chk("e_instr", Instr, w);
        chk("e_pc", PC, exp_pc);
        chk("e_pc4", PC4, exp_pc + 32'd4);
        chk("e_req", 32'(imem_req), 32'd0);
        cur_instr = w;
    endtask

    task automatic commit(input logic [2:0] op, input logic z,
                          input logic [15:0] imm, input logic [25:0] idx,
                          input logic [31:0] rega, input int d);
        for (int i = 0; i < d; i++) begin
            Advance = 1'b0;
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            nPCOp = 3'($urandom_range(0, 7));
            RegA = $urandom;
            @(negedge clk);
            chk("h_valid", 32'(InstrValid), 32'd1);
            chk("h_instr", Instr, cur_instr);
            chk("h_pc", PC, exp_pc);
            chk("h_req", 32'(imem_req), 32'd0);
        end
        Advance = 1'b1;
        nPCOp = op;
        Zero = z;
        Imm16 = imm;
        Index26 = idx;
        RegA = rega;
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        @(negedge clk);
        Advance = 1'b0;
        imem_ack = 1'b0;
        exp_pc = ref_npc(exp_pc, op, z, imm, idx, rega);
        chk("c_valid", 32'(InstrValid), 32'd0);
        chk("c_req", 32'(imem_req), 32'd1);
        chk("c_addr", imem_addr, exp_pc);
        chk("c_pc", PC, exp_pc);
    endtask

    task automatic reset_mid_fetch();
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("mr_instr", Instr, 32'd0);
        chk("mr_valid", 32'(InstrValid), 32'd0);
        chk("mr_pc", PC, RST_PC);
        chk("mr_req", 32'(imem_req), 32'd0);
        reset = 1'b1;
        exp_pc = RST_PC;
        @(negedge clk);
    endtask

    initial begin
        do_reset();

        fetch(32'h3401_0005, 0);
        commit(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 0);
        chk("seq_addr", imem_addr, 32'h0000_3004);

        fetch(32'h1111_2222, 3);
        commit(3'b011, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 1);
        fetch(32'h1000_FFFC, 0);
        commit(3'b001, 1'b1, 16'hFFFC, 26'h0, 32'h0, 0);
        chk("beq_t_addr", imem_addr, 32'h0000_3004);

        fetch(32'h0, 1);
        commit(3'b011, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 0);
        fetch(32'h1000_FFFC, 0);
        commit(3'b001, 1'b0, 16'hFFFC, 26'h0, 32'h0, 2);
        chk("beq_nt_addr", imem_addr, 32'h0000_3014);

        fetch(32'h2, 0);
        commit(3'b011, 1'b0, 16'h0, 26'h0, 32'h0000_3020, 0);
        fetch(32'h0C00_0C10, 0);
        chk("jal_pc4", PC4, 32'h0000_3024);
        commit(3'b010, 1'b0, 16'h0, 26'h000_0C10, 32'h0, 0);
        chk("j_addr", imem_addr, 32'h0000_3040);

        fetch(32'h3, 2);
        commit(3'b011, 1'b0, 16'h0, 26'h0, 32'h0000_3107, 0);
        chk("jr_addr", imem_addr, 32'h0000_3104);
        fetch(32'h4, 0);
        commit(3'b101, 1'b1, 16'h1234, 26'h3FF_FFFF, 32'h0, 0);
        chk("rsv_addr", imem_addr, 32'h0000_3108);

        fetch(32'h5, 0);
        commit(3'b011, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF, 0);
        fetch(32'h6, 1);
        chk("wrap_pc4", PC4, 32'h0000_0000);
        commit(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        fetch(32'h7, 0);
        commit(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 0);
        reset_mid_fetch();

        for (int n = 0; n < 200; n++) begin
            fetch($urandom, $urandom_range(0, 3));
            commit(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   16'($urandom), 26'($urandom), $urandom,
                   $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                reset_mid_fetch();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit: the stage directly upstream of the main decoder.
- Holds the architectural PC and fetches the instruction word from instruction memory over a req/ack handshake.
- Presents Instr/PC/PC4 to decode and execute.
- On commit, computes the next PC from the decoder's 3-bit nPCOp plus branch/jump operands.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- nPCOp  in  3  next-PC select from decoder: 000 PC+4, 001 beq, 010 j/jal, 011 jr, 1xx reserved.
- Zero  in  1  ALU equality flag; qualifies beq.
- Imm16  in  16  branch offset field (Instr[15:0]).
- Index26  in  26  jump index field (Instr[25:0]).
- RegA  in  32  rs register value; jr target.
- Advance  in  1  current instruction is complete; commit next PC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equals PC.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- Instr  out  32  latched instruction.
- InstrValid  out  1  Instr/PC/PC4 valid for decode/execute.
- PC  out  32  address of Instr.
- PC4  out  32  PC+4 (jal link value).

Behaviour:
- Reset (reset==0 at a rising edge):
  - PC=RESET_PC, Instr=0, InstrValid=0, FSM=IDLE.
  - imem_req=0 throughout reset and in IDLE.
  - Reset wins over every other event, including mid-fetch with ack pending.
  - Any ack arriving during reset is discarded.
- FSM states:
  - IDLE: next state FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=PC. Stay in FETCH while imem_ack=0. When imem_ack=1: Instr<=imem_rdata, InstrValid<=1, go to EXEC.
  - EXEC: imem_req=0, InstrValid=1, Instr held stable. While Advance=0, hold everything. When Advance=1: PC<=NextPC, InstrValid<=0, go to FETCH.
- Latency:
  - A zero-wait memory (ack in the first FETCH cycle) gives InstrValid=1 on the following cycle.
  - Advance in the first EXEC cycle gives a new request on the next cycle.
  - Best case is 2 cycles per instruction.
  - The first request is issued 1 cycle after reset is released (the IDLE cycle).
- Ignored inputs:
  - Advance is ignored in IDLE and FETCH.
  - imem_ack is ignored outside FETCH.
- Next-PC rules:
  - nPCOp, Zero, Imm16, Index26 and RegA are sampled only in the EXEC cycle where Advance=1.
  - PC4 = PC+4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - 000: NextPC=PC4.
  - 001: if Zero=1, NextPC = PC4 + sign-extended {Imm16,2'b00}, modulo 2^32. If Zero=0, NextPC=PC4.
  - 010: NextPC={PC4[31:28], Index26, 2'b00}.
  - 011: NextPC={RegA[31:2], 2'b00}. Low two bits are forced to zero; no exception is raised.
  - 1xx: NextPC=PC4.
- Output timing:
  - PC4 is combinational from the PC register.
  - PC, Instr and InstrValid are registered.
  - imem_addr is valid whenever imem_req=1.

Test Plan:
- Reset, then zero-wait memory returning 32'h3401_0005 with Advance held 1 and nPCOp=000:
  - imem_req rises 1 cycle after reset release, with imem_addr=32'h0000_3000.
  - InstrValid=1 with Instr=32'h3401_0005 on the next cycle.
  - The next request has imem_addr=32'h0000_3004.
- Memory delays ack 3 cycles: imem_req and imem_addr stay stable for 4 cycles, and InstrValid stays 0 until the cycle after ack.
- beq at PC=32'h0000_3010 with Imm16=16'hFFFC:
  - Zero=1: next fetch address is 32'h0000_3004.
  - Zero=0: next fetch address is 32'h0000_3014.
- j with PC=32'h0000_3020 and Index26=26'h000_0C10: next address is 32'h0000_3040. jal in the same state: PC4=32'h0000_3024 while in EXEC.
- jr with RegA=32'h0000_3107: next address is 32'h0000_3104. nPCOp=3'b101: next address is PC+4.
- Error and corner cases:
  - reset=0 asserted while in FETCH with ack arriving in the same cycle: Instr stays 0, InstrValid=0, PC=RESET_PC.
  - Advance pulsed during FETCH: no PC change.
  - PC=32'hFFFF_FFFC with nPCOp=000: next address is 32'h0000_0000.
